// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blink_pkg
//  Description : Shared types for the LED pattern bank: the channel mode
//                encoding and the configuration FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package blink_pkg;

   // Channel operating mode, encoded exactly as driven on cfg_mode
   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_ONESHOT = 2'd3
   } mode_e;

   // Configuration handshake FSM
   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } cfg_state_e;

endpackage : blink_pkg
`default_nettype wire

// File: rtl/blink_chan.sv
`default_nettype none
// ============================================================================
//  Module      : blink_chan
//  Description : One LED channel: holds mode/period/duty and a phase counter
//                that advances on each pattern tick; drives a registered LED.
//  Revision    : 1.0 - initial release
// ============================================================================
module blink_chan
   import blink_pkg::*;
#(
   parameter int PERIOD_W = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                tick_i,
   input  logic                load_i,
   input  logic [1:0]          mode_i,
   input  logic [PERIOD_W-1:0] period_i,
   input  logic [PERIOD_W-1:0] duty_i,
   output logic                led_o
);

   localparam logic [PERIOD_W-1:0] c_one = PERIOD_W'(1);

   mode_e               mode_q,   mode_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] duty_q,   duty_d;
   logic [PERIOD_W-1:0] phase_q,  phase_d;
   logic                led_q,    led_d;
   logic [PERIOD_W-1:0] last_phase;

   // Next-state: a load overrides the tick so the loading tick never advances phase
   always_comb begin
      mode_d     = mode_q;
      period_d   = period_q;
      duty_d     = duty_q;
      phase_d    = phase_q;
      // A zero period behaves as a period of one, so the last phase is 0
      last_phase = (period_q == '0) ? '0 : (period_q - c_one);

      if (load_i) begin
         mode_d   = mode_e'(mode_i);
         period_d = period_i;
         duty_d   = duty_i;
         phase_d  = '0;
      end else if (tick_i) begin
         if (phase_q >= last_phase) begin
            phase_d = '0;
         end else begin
            phase_d = phase_q + c_one;
         end
         // A one-shot retires on the tick that brings phase to its last value
         if ((mode_q == MODE_ONESHOT) && (phase_d == last_phase)) begin
            mode_d = MODE_OFF;
         end
      end

      // LED is computed from next-state so it lands one clock after the event
      case (mode_d)
         MODE_OFF: led_d = 1'b0;
         MODE_ON:  led_d = 1'b1;
         default:  led_d = (phase_d < duty_d);
      endcase
   end

   // Channel state registers with asynchronous reset to OFF, period 1
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_q   <= MODE_OFF;
         period_q <= c_one;
         duty_q   <= '0;
         phase_q  <= '0;
         led_q    <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         period_q <= period_d;
         duty_q   <= duty_d;
         phase_q  <= phase_d;
         led_q    <= led_d;
      end
   end

   assign led_o = led_q;

endmodule : blink_chan
`default_nettype wire

// File: rtl/blink_bank.sv
`default_nettype none
// ============================================================================
//  Module      : blink_bank
//  Description : Bank of independently configured LED pattern channels
//                sharing one tick prescaler and one configuration port whose
//                writes are applied on tick boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module blink_bank
   import blink_pkg::*;
#(
   parameter int  CLOCK_FREQ = 12_000_000,
   parameter int  TICK_HZ    = 1000,
   parameter int  CHANNELS   = 4,
   parameter int  PERIOD_W   = 16,
   localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CHAN_W-1:0]   cfg_chan,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [PERIOD_W-1:0] cfg_duty,
   output logic [CHANNELS-1:0] led,
   output logic                tick
);

   localparam int TICK_DIV = CLOCK_FREQ / TICK_HZ;
   localparam int CNT_W    = $clog2(TICK_DIV);

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   cfg_state_e          state_q, state_d;
   logic [CHAN_W-1:0]   hold_chan_q,   hold_chan_d;
   mode_e               hold_mode_q,   hold_mode_d;
   logic [PERIOD_W-1:0] hold_period_q, hold_period_d;
   logic [PERIOD_W-1:0] hold_duty_q,   hold_duty_d;
   logic                commit;
   logic [CHANNELS-1:0] load;

   // Tick is a decode of the prescaler, so it is low while reset holds cnt at 0
   assign tick = (cnt_q == c_cnt_last);

   // Prescaler next count: 0..TICK_DIV-1 then wrap
   always_comb begin
      cnt_d = (cnt_q == c_cnt_last) ? '0 : (cnt_q + c_cnt_one);
   end

   // Config FSM: capture in IDLE, apply on the next tick while PENDING
   always_comb begin
      state_d       = state_q;
      hold_chan_d   = hold_chan_q;
      hold_mode_d   = hold_mode_q;
      hold_period_d = hold_period_q;
      hold_duty_d   = hold_duty_q;
      cfg_ready     = 1'b0;
      commit        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            // A transfer in a tick cycle waits for the following tick
            if (cfg_valid) begin
               hold_chan_d   = cfg_chan;
               hold_mode_d   = mode_e'(cfg_mode);
               hold_period_d = cfg_period;
               hold_duty_d   = cfg_duty;
               state_d       = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (tick) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Prescaler, FSM state and holding register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q         <= '0;
         state_q       <= ST_IDLE;
         hold_chan_q   <= '0;
         hold_mode_q   <= MODE_OFF;
         hold_period_q <= '0;
         hold_duty_q   <= '0;
      end else begin
         cnt_q         <= cnt_d;
         state_q       <= state_d;
         hold_chan_q   <= hold_chan_d;
         hold_mode_q   <= hold_mode_d;
         hold_period_q <= hold_period_d;
         hold_duty_q   <= hold_duty_d;
      end
   end

   // One channel per LED; an index with no matching channel loads nothing
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      assign load[i] = commit && (hold_chan_q == CHAN_W'(i));

      blink_chan #(
         .PERIOD_W (PERIOD_W)
      ) u_chan (
         .clock    (clock),
         .reset    (reset),
         .tick_i   (tick),
         .load_i   (load[i]),
         .mode_i   (hold_mode_q),
         .period_i (hold_period_q),
         .duty_i   (hold_duty_q),
         .led_o    (led[i])
      );
   end : g_chan

endmodule : blink_bank
`default_nettype wire

// File: tb/tb_blink_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blink_bank
//  Description : Self-checking bench for blink_bank. Stimulus pushes the
//                hand-computed LED/ready state expected after each tick; a
//                monitor pops one entry per tick and compares. A second
//                three-channel instance sees the same writes, so channel
//                index 3 is out of range there and must be discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_blink_bank;

   localparam int CLOCK_FREQ = 1000;
   localparam int TICK_HZ    = 100;
   localparam int PERIOD_W   = 8;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                cfg_valid = 1'b0;
   logic [1:0]          cfg_chan = '0;
   logic [1:0]          cfg_mode = '0;
   logic [PERIOD_W-1:0] cfg_period = '0;
   logic [PERIOD_W-1:0] cfg_duty = '0;
   logic                cfg_ready, cfg_ready3;
   logic [3:0]          led;
   logic [2:0]          led3;
   logic                tick, tick3;

   blink_bank #(
      .CLOCK_FREQ (CLOCK_FREQ), .TICK_HZ (TICK_HZ), .CHANNELS (4), .PERIOD_W (PERIOD_W)
   ) dut (
      .clock (clock), .reset (reset), .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
      .cfg_chan (cfg_chan), .cfg_mode (cfg_mode), .cfg_period (cfg_period),
      .cfg_duty (cfg_duty), .led (led), .tick (tick)
   );

   blink_bank #(
      .CLOCK_FREQ (CLOCK_FREQ), .TICK_HZ (TICK_HZ), .CHANNELS (3), .PERIOD_W (PERIOD_W)
   ) dut3 (
      .clock (clock), .reset (reset), .cfg_valid (cfg_valid), .cfg_ready (cfg_ready3),
      .cfg_chan (cfg_chan), .cfg_mode (cfg_mode), .cfg_period (cfg_period),
      .cfg_duty (cfg_duty), .led (led3), .tick (tick3)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         cyc;
      logic [3:0] led;
      logic       ready;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   // Clock edges since the last reset release
   always @(posedge clock or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected state after tick number k (counted from reset release)
   task automatic push(input int k, input logic [3:0] l, input logic r);
      exp_t e;
      e.cyc   = k * 10;
      e.led   = l;
      e.ready = r;
      q.push_back(e);
   endtask

   // Returns at the falling edge inside the next tick cycle
   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (tick !== 1'b1 && n < 40);
      if (tick !== 1'b1) check("tick_timeout", {31'b0, tick}, 32'd1);
   endtask

   // One-cycle write starting at a falling edge; returns at the next one
   task automatic write(input logic [1:0] ch, input logic [1:0] m,
                        input logic [7:0] p, input logic [7:0] d);
      cfg_valid  = 1'b1;
      cfg_chan   = ch;
      cfg_mode   = m;
      cfg_period = p;
      cfg_duty   = d;
      @(negedge clock);
      cfg_valid  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clock);
         n++;
      end
      check("queue_drain", q.size(), 32'd0);
   endtask

   // Monitor: on each tick, compare the post-tick state with the next expectation
   initial begin : monitor
      exp_t e;
      int   tcyc;
      forever begin
         @(negedge clock);
         if (tick === 1'b1) begin
            tcyc = cyc + 1;
            check("tick3_align", {31'b0, tick3}, 32'd1);
            @(negedge clock);
            if (q.size() != 0) begin
               e = q.pop_front();
               check("tick_cycle", tcyc, e.cyc);
               check("led", {28'b0, led}, {28'b0, e.led});
               check("led_3ch", {29'b0, led3}, {29'b0, e.led[2:0]});
               check("cfg_ready", {31'b0, cfg_ready}, {31'b0, e.ready});
               check("cfg_ready_3ch", {31'b0, cfg_ready3}, {31'b0, e.ready});
            end
         end
      end
   end

   initial begin : stimulus
      repeat (3) @(negedge clock);
      check("rst_led", {28'b0, led}, 32'd0);
      check("rst_ready", {31'b0, cfg_ready}, 32'd1);
      check("rst_tick", {31'b0, tick}, 32'd0);
      reset = 1'b0;

      // Idle ticks at 10, 20, 30
      push(1, 4'b0000, 1'b1);
      push(2, 4'b0000, 1'b1);
      push(3, 4'b0000, 1'b1);
      repeat (3) wait_tick();

      // ch1 BLINK period 4 duty 1: 1,0,0,0 per tick
      @(negedge clock);
      write(2'd1, 2'd2, 8'd4, 8'd1);
      check("ready_pending", {31'b0, cfg_ready}, 32'd0);
      push(4, 4'b0010, 1'b1);
      push(5, 4'b0000, 1'b1);
      push(6, 4'b0000, 1'b1);
      push(7, 4'b0000, 1'b1);
      push(8, 4'b0010, 1'b1);
      repeat (5) wait_tick();

      // ch2 ONESHOT period 3 duty 2: high, high, low, then OFF
      @(negedge clock);
      write(2'd2, 2'd3, 8'd3, 8'd2);
      push(9,  4'b0100, 1'b1);
      push(10, 4'b0100, 1'b1);
      push(11, 4'b0000, 1'b1);
      push(12, 4'b0010, 1'b1);
      push(13, 4'b0000, 1'b1);
      repeat (5) wait_tick();

      // ch0 BLINK period 0 duty 0: constant 0
      @(negedge clock);
      write(2'd0, 2'd2, 8'd0, 8'd0);
      push(14, 4'b0000, 1'b1);
      push(15, 4'b0000, 1'b1);
      repeat (2) wait_tick();

      // ch0 BLINK period 5 duty 9: constant 1
      @(negedge clock);
      write(2'd0, 2'd2, 8'd5, 8'd9);
      push(16, 4'b0011, 1'b1);
      push(17, 4'b0001, 1'b1);
      push(18, 4'b0001, 1'b1);
      push(19, 4'b0001, 1'b1);
      push(20, 4'b0011, 1'b1);
      repeat (5) wait_tick();

      // ch3 ON written during a tick cycle: held over tick 21, loaded on 22;
      // the three-channel instance must discard it
      wait_tick();
      push(21, 4'b0001, 1'b0);
      push(22, 4'b1001, 1'b1);
      push(23, 4'b1001, 1'b1);
      push(24, 4'b1011, 1'b1);
      write(2'd3, 2'd1, 8'd1, 8'd0);
      repeat (3) wait_tick();
      drain();

      // Reset while PENDING drops the held write
      write(2'd2, 2'd1, 8'd1, 8'd0);
      check("ready_pending2", {31'b0, cfg_ready}, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check("rst2_led", {28'b0, led}, 32'd0);
      check("rst2_ready", {31'b0, cfg_ready}, 32'd1);
      reset = 1'b0;
      push(1, 4'b0000, 1'b1);
      push(2, 4'b0000, 1'b1);
      repeat (2) wait_tick();
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_blink_bank
`default_nettype wire
